// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t        frame FSM states (IDLE, START, DATA, STOP)
//   MIN_RATE          smallest clocks-per-bit accepted by the receiver
//   DEFAULT_RX_DEPTH  default receive FIFO depth
//   clamp_rate()      returns max(rate, MIN_RATE)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int MIN_RATE         = 4;
    localparam int DEFAULT_RX_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Rates below MIN_RATE leave too few clocks for a meaningful mid-bit sample.
    function automatic logic [15:0] clamp_rate(input logic [15:0] rate);
        return (rate < 16'(MIN_RATE)) ? 16'(MIN_RATE) : rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if: received-byte stream from the UART receiver to its consumer.
//   data   head byte of the receive FIFO (0 when empty)
//   valid  FIFO non-empty
//   ready  consumer accepts the head byte when valid && ready
// Modports: master (receiver side), slave (consumer side).
// -----------------------------------------------------------------------------
interface uart_rx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo: byte FIFO holding received characters.
//   clk, nReset  clock and synchronous active-high reset
//   push, din    write request and byte; ignored when full unless popping
//   pop          read request; ignored when empty
//   dout         head byte, forced to 0 while empty
//   count        number of stored entries (0..DEPTH)
//   full, empty  status flags derived from count
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_RX_DEPTH
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth wraps naturally
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by count_q and dout is masked while empty, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver with a receive FIFO and RTS flow control.
//   clk, nReset  clock and synchronous active-high reset
//   rx           asynchronous serial line, idle high
//   rate         clocks per bit, captured at each start-bit detection
//   rx_out       byte stream to the consumer (data/valid/ready)
//   rts          registered; high while at least 2 FIFO slots are free
//   frame_err    one-cycle pulse when a stop bit samples low
//   overrun      one-cycle pulse when a byte is dropped on a full FIFO
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_RX_DEPTH
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        rx,
    input  logic [15:0] rate,
    uart_rx_if.master   rx_out,
    output logic        rts,
    output logic        frame_err,
    output logic        overrun
);

    localparam int AW = $clog2(DEPTH);

    rx_state_t   state_q,     state_d;
    logic [1:0]  sync_q,      sync_d;
    logic [1:0]  sync_live_q, sync_live_d;
    logic        rx_prev_q,   rx_prev_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [15:0] eff_rate_q,  eff_rate_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q,   overrun_d;
    logic        rts_q,       rts_d;

    logic        rx_s, fall, push, push_ok, pop, bad_stop;
    logic [15:0] half;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_count, count_next;
    logic        fifo_full, fifo_empty;

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .nReset (nReset),
        .push   (push),
        .pop    (pop),
        .din    (shift_q),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rx_s          = sync_q[1];
    assign rx_out.data   = fifo_dout;
    assign rx_out.valid  = !fifo_empty;
    assign rts           = rts_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

    // rx_prev_q stays 0 until the synchronizer holds real line samples, so a
    // line that is already low when reset releases never looks like an edge.
    assign fall = rx_prev_q && !rx_s;
    assign half = {1'b0, eff_rate_q[15:1]};

    always_comb begin
        sync_d      = {sync_q[0], rx};
        sync_live_d = {sync_live_q[0], 1'b1};
        rx_prev_d   = sync_live_q[1] && rx_s;
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        eff_rate_d  = eff_rate_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        bad_stop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    eff_rate_d = clamp_rate(rate);
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                // Half a bit after the edge: still low means a real start bit.
                if (cnt_q == half - 16'd1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == eff_rate_q - 16'd1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == eff_rate_q - 16'd1) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    push     = rx_s;
                    bad_stop = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase

        pop         = rx_out.valid && rx_out.ready;
        push_ok     = push && (!fifo_full || pop);
        frame_err_d = bad_stop;
        overrun_d   = push && fifo_full && !pop;

        // Mirror of the FIFO's next count so rts lines up with the new occupancy.
        count_next = fifo_count;
        if (push_ok && !pop)      count_next = fifo_count + 1'b1;
        else if (!push_ok && pop) count_next = fifo_count - 1'b1;
        rts_d = (count_next <= (AW+1)'(DEPTH - 2));
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            sync_live_q <= 2'b00;
            rx_prev_q   <= 1'b0;
            cnt_q       <= '0;
            eff_rate_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rts_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            sync_live_q <= sync_live_d;
            rx_prev_q   <= rx_prev_d;
            cnt_q       <= cnt_d;
            eff_rate_q  <= eff_rate_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rts_q       <= rts_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx: directed self-checking bench for uart_rx (DEPTH=4).
// Line bits are driven on falling clock edges; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        nReset;
    logic        rx;
    logic [15:0] rate;
    logic        rts, frame_err, overrun;

    uart_rx_if bus ();

    uart_rx #(.DEPTH(4)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .rx        (rx),
        .rate      (rate),
        .rx_out    (bus.master),
        .rts       (rts),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ovr_cnt  = 0;
    int fe0, ovr0;
    logic found;

    // Pulse counters: each one-cycle pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt  <= fe_cnt + 1;
        if (overrun)   ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit plus 8 data bits, LSB first, r clocks each; returns at the
    // falling edge where the stop bit is due.
    task automatic send_head(input logic [7:0] b, input int r);
        rx = 1'b0;
        repeat (r) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (r) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int r);
        send_head(b, r);
        rx = stop_v;
        repeat (r) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_one(input string tag, input logic [7:0] exp);
        check(tag, 16'(bus.data), 16'(exp));
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    initial begin
        nReset    = 1'b1;
        rx        = 1'b1;
        rate      = 16'd16;
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", 16'(bus.valid), 16'd0);
        check("rst_data",  16'(bus.data),  16'd0);
        check("rst_rts",   16'(rts),       16'd1);
        check("rst_fe",    16'(frame_err), 16'd0);
        check("rst_ovr",   16'(overrun),   16'd0);
        check("rst_state", 16'(dut.state_q), 16'(IDLE));
        nReset = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5 at rate 16: valid within 2 clocks of the stop mid-sample
        fe0 = fe_cnt;
        send_head(8'hA5, 16);
        rx = 1'b1;
        repeat (9) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("a5_valid", 16'(found), 16'd1);
        check("a5_data",  16'(bus.data), 16'h00A5);
        repeat (8) @(negedge clk);
        check("a5_no_fe", 16'(fe_cnt - fe0), 16'd0);
        pop_one("a5_pop", 8'hA5);
        check("a5_empty", 16'(bus.valid), 16'd0);

        // 5-clock low glitch
        fe0  = fe_cnt;
        ovr0 = ovr_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("gl_start", 16'(dut.state_q), 16'(START));
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("gl_idle",  16'(dut.state_q), 16'(IDLE));
        check("gl_valid", 16'(bus.valid), 16'd0);
        check("gl_fe",    16'(fe_cnt - fe0), 16'd0);
        check("gl_ovr",   16'(ovr_cnt - ovr0), 16'd0);

        // 0x3C with a low stop bit
        fe0 = fe_cnt;
        send_byte(8'h3C, 1'b0, 16);
        check("fe_pulse", 16'(fe_cnt - fe0), 16'd1);
        check("fe_valid", 16'(bus.valid), 16'd0);

        // Fill past capacity with ready low
        fe0  = fe_cnt;
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, 16);
            if (i == 2) check("rts_2", 16'(rts), 16'd1);
            if (i == 3) check("rts_3", 16'(rts), 16'd0);
        end
        check("ovr_once",  16'(ovr_cnt - ovr0), 16'd1);
        check("ovr_no_fe", 16'(fe_cnt - fe0), 16'd0);
        for (int i = 1; i <= 4; i++) pop_one("ovr_pop", 8'(i));
        check("ovr_empty", 16'(bus.valid), 16'd0);
        check("ovr_rts",   16'(rts), 16'd1);

        // Full FIFO, pop coincides with the 5th stop sample
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 16);
        check("pp_rts", 16'(rts), 16'd0);
        send_head(8'h05, 16);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("pp_head",  16'(bus.data), 16'h0001);
        check("pp_valid", 16'(bus.valid), 16'd1);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        repeat (7) @(negedge clk);
        check("pp_no_ovr", 16'(ovr_cnt - ovr0), 16'd0);
        for (int i = 2; i <= 5; i++) pop_one("pp_pop", 8'(i));
        check("pp_empty", 16'(bus.valid), 16'd0);

        // Reset during DATA bit 3, line held low across release
        send_byte(8'h77, 1'b1, 16);
        check("mr_prefill", 16'(bus.valid), 16'd1);
        fe0  = fe_cnt;
        ovr0 = ovr_cnt;
        rx = 1'b0;
        repeat (16 * 4 + 8) @(negedge clk);
        check("mr_in_data", 16'(dut.state_q), 16'(DATA));
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        nReset = 1'b0;
        @(negedge clk);
        check("mr_valid", 16'(bus.valid), 16'd0);
        check("mr_data",  16'(bus.data),  16'd0);
        check("mr_rts",   16'(rts),       16'd1);
        repeat (30) @(negedge clk);
        check("mr_low_ignored", 16'(dut.state_q), 16'(IDLE));
        check("mr_low_valid",   16'(bus.valid), 16'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rate = 16'd2;
        send_byte(8'h81, 1'b1, 4);
        check("mr_81_valid", 16'(bus.valid), 16'd1);
        check("mr_81_data",  16'(bus.data),  16'h0081);
        check("mr_no_fe",    16'(fe_cnt - fe0),   16'd0);
        check("mr_no_ovr",   16'(ovr_cnt - ovr0), 16'd0);
        pop_one("mr_pop", 8'h81);
        check("mr_empty", 16'(bus.valid), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port nReset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rate  input  16  clocks per bit, sampled at each start-bit detection.
REQ-006 SHALL have port data  output  8  FIFO head byte.
REQ-007 SHALL have port valid  output  1  FIFO non-empty.
REQ-008 SHALL have port ready  input  1  consumer accepts head when valid && ready.
REQ-009 SHALL have port rts  output  1  high when at least 2 FIFO slots free.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse on byte dropped because FIFO full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized signal.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: a 1->0 transition on synchronized rx SHALL latch eff_rate = max(rate, 4), clear the bit counter, and enter START.
REQ-015 START: after eff_rate/2 clocks (integer division), rx=0 SHALL enter DATA; rx=1 SHALL return to IDLE as a glitch, with no output.
REQ-016 DATA: SHALL sample rx every eff_rate clocks, 8 samples, shifting LSB-first, then enter STOP.
REQ-017 STOP: after eff_rate clocks, sample rx; 1 SHALL push the byte, 0 SHALL pulse frame_err with no push; both paths SHALL enter IDLE.
REQ-018 The baud counter SHALL be 16 bits and reload to 0 at every sample point; changes to rate mid-frame SHALL NOT affect the current frame.
REQ-019 A push when the FIFO holds DEPTH entries and no pop occurs that cycle SHALL drop the byte and pulse overrun.
REQ-020 A push and a pop in the same cycle SHALL both succeed, including when full, without overrun.
REQ-021 Pop SHALL occur when valid && ready; data SHALL show the next entry on the following cycle.
REQ-022 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.
REQ-023 Latency SHALL be: valid rises on the cycle after the STOP sample when the FIFO was empty.
REQ-024 rts SHALL be registered, computed as count <= DEPTH-2 from the next-state count.
REQ-025 frame_err and overrun SHALL NOT assert in the same cycle as each other.

Reset
REQ-026 With nReset high at a clock edge: state=IDLE, counters=0, FIFO empty, valid=0, data=0, rts=1, frame_err=0, overrun=0, synchronizer=1.
REQ-027 nReset asserted mid-frame SHALL abandon the frame and flush the FIFO, with no pulse on any output.
REQ-028 After reset release, a byte SHALL be received only on a fresh 1->0 edge; a line already low SHALL be ignored until it returns high.

Structure
REQ-029 Package uart_pkg SHALL hold the rx_state_t enum, MIN_RATE=4, and DEFAULT_RX_DEPTH=4.
REQ-030 The FIFO SHALL be sub-module uart_rx_fifo (push, pop, din, dout, count, full, empty); the frame FSM SHALL stay in uart_rx.
REQ-031 The block SHALL feed the AHBUart receive data register; rts SHALL drive AHBUart's rts pin path.

Verification
REQ-032 rate=16, send 0xA5 8N1 -> valid rises with data=0xA5 within 2 clocks of the stop mid-sample, and frame_err=0.
REQ-033 rate=16, low glitch of 5 clocks on rx -> state returns to IDLE, and valid, frame_err, and overrun stay 0.
REQ-034 rate=16, send 0x3C with stop bit driven 0 -> one frame_err pulse, valid stays 0.
REQ-035 ready=0, send 5 bytes 0x01..0x05 with DEPTH=4 -> rts falls after the 3rd byte, overrun pulses once on the 5th, and pops return 0x01..0x04.
REQ-036 FIFO full with ready=1 during the 5th stop sample -> no overrun, and 0x05 is retained.
REQ-037 nReset pulsed during DATA bit 3, then rate=2 and send 0x81 -> clean idle, byte received correctly at eff_rate 4.
